lat_sram: RTL and testbench

- Parametrised successor to the single-port SRAM model used by the multi-cycle CPU.
- Generalises data width and depth and adds a programmable access latency behind a REQ/READY request handshake.
- Signals completion with a one-cycle RVALID pulse and an out-of-range error flag.
- Sits between the multi-cycle controller and instruction/data storage, so slow-memory stalls can be modelled.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/sram_array.sv | 47 ++++
 rtl/lat_sram.sv | 129 ++++++++++++
 tb/tb_lat_sram.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and parameter sanity checks for the latency-programmable SRAM.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int nbytes(input int dwidth);
    return dwidth / 8;
  endfunction

  function automatic bit latency_ok(input int latency);
    return latency >= 1;
  endfunction

  function automatic bit dwidth_ok(input int dwidth);
    return (dwidth > 0) && (dwidth % 8 == 0);
  endfunction

endpackage

// File: rtl/sram_array.sv
// Word-addressed storage with byte-enable writes and a registered read port.
module sram_array
  import mem_pkg::*;
#(
  parameter string ROMDATA = "",
  parameter int    DWIDTH  = 32,
  parameter int    AWIDTH  = 12,
  parameter int    SIZE    = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic                    re,
  input  logic [AWIDTH-1:0]       addr,
  input  logic [nbytes(DWIDTH)-1:0] be,
  input  logic [DWIDTH-1:0]       di,
  output logic [DWIDTH-1:0]       dout
);

  localparam int NB = nbytes(DWIDTH);

  logic [DWIDTH-1:0] mem [SIZE];
  logic [DWIDTH-1:0] dout_q;
  logic [DWIDTH-1:0] dout_d;

  // Contents are deliberately left out of reset so a reset never wipes memory.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= di[8*i +: 8];
      end
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (re) dout_d = mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/lat_sram.sv
// Single-port SRAM behind a REQ/READY handshake with a programmable access latency.
module lat_sram
  import mem_pkg::*;
#(
  parameter string ROMDATA = "",
  parameter int    DWIDTH  = 32,
  parameter int    AWIDTH  = 12,
  parameter int    SIZE    = 4096,
  parameter int    LATENCY = 2
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                REQ,
  output logic                READY,
  input  logic [AWIDTH-1:0]   ADDR,
  input  logic                WEN,
  input  logic [DWIDTH/8-1:0] BE,
  input  logic [DWIDTH-1:0]   DI,
  output logic [DWIDTH-1:0]   DOUT,
  output logic                RVALID,
  output logic                ERR
);

  localparam int NB = nbytes(DWIDTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [AWIDTH:0] SIZE_L = (AWIDTH + 1)'(SIZE);

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("lat_sram: LATENCY must be >= 1");
  end
  if (!dwidth_ok(DWIDTH)) begin : g_bad_dwidth
    $error("lat_sram: DWIDTH must be a positive multiple of 8");
  end
  if (SIZE > (1 << AWIDTH)) begin : g_bad_size
    $error("lat_sram: SIZE exceeds 2**AWIDTH");
  end

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [NB-1:0]     be_q, be_d;
  logic [DWIDTH-1:0] di_q, di_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;

  logic accept;
  logic complete;
  logic in_range;
  logic arr_we;
  logic arr_re;

  assign accept   = REQ && (state_q == IDLE);
  assign complete = (state_q == BUSY) && (cnt_q == '0);
  assign in_range = {1'b0, addr_q} < SIZE_L;
  assign arr_we   = complete && !wen_q && in_range;
  assign arr_re   = complete &&  wen_q && in_range;

  // The counter is only loaded on accept, so it counts down once per request and never wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    be_d     = be_q;
    di_d     = di_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    if (accept) begin
      state_d = BUSY;
      cnt_d   = CW'(LATENCY - 1);
      addr_d  = ADDR;
      wen_d   = WEN;
      be_d    = BE;
      di_d    = DI;
    end else if (state_q == BUSY) begin
      if (cnt_q == '0) begin
        state_d  = IDLE;
        rvalid_d = 1'b1;
        err_d    = !in_range;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b1;
      be_q     <= '0;
      di_q     <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      be_q     <= be_d;
      di_q     <= di_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  sram_array #(
    .ROMDATA (ROMDATA),
    .DWIDTH  (DWIDTH),
    .AWIDTH  (AWIDTH),
    .SIZE    (SIZE)
  ) u_array (
    .clk   (CLK),
    .rst_n (RSTN),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (addr_q),
    .be    (be_q),
    .di    (di_q),
    .dout  (DOUT)
  );

  assign READY  = (state_q == IDLE);
  assign RVALID = rvalid_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_lat_sram.sv
// Directed bench for lat_sram: one LATENCY=3/SIZE=1024 instance and one LATENCY=1/SIZE=16 instance.
module tb_lat_sram;

  logic        clk;
  logic        rstn;
  logic [1:0]  req;
  logic [1:0]  ready;
  logic [1:0]  wen;
  logic [1:0]  rvalid;
  logic [1:0]  err;
  logic [11:0] addr [2];
  logic [3:0]  be   [2];
  logic [31:0] di   [2];
  logic [31:0] dout [2];
  logic [31:0] last_dout [2];

  int tests_run;
  int tests_failed;

  lat_sram #(.DWIDTH(32), .AWIDTH(12), .SIZE(1024), .LATENCY(3)) dut0 (
    .CLK(clk), .RSTN(rstn), .REQ(req[0]), .READY(ready[0]), .ADDR(addr[0]),
    .WEN(wen[0]), .BE(be[0]), .DI(di[0]), .DOUT(dout[0]), .RVALID(rvalid[0]), .ERR(err[0])
  );

  lat_sram #(.DWIDTH(32), .AWIDTH(12), .SIZE(16), .LATENCY(1)) dut1 (
    .CLK(clk), .RSTN(rstn), .REQ(req[1]), .READY(ready[1]), .ADDR(addr[1]),
    .WEN(wen[1]), .BE(be[1]), .DI(di[1]), .DOUT(dout[1]), .RVALID(rvalid[1]), .ERR(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; for reads 'data' is also the expected DOUT.
  task automatic applyStimulus(input int d, input logic w, input logic [11:0] a,
                               input logic [3:0] b, input logic [31:0] data,
                               input int lat, input logic exp_err, input string tag);
    logic [31:0] exp_dout;
    req[d] = 1'b1; wen[d] = w; addr[d] = a; be[d] = b; di[d] = data;
    checkOutput({tag, "_ready_before"}, 32'(ready[d]), 32'd1);
    @(posedge clk); #1;
    req[d] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      checkOutput({tag, "_ready_busy"}, 32'(ready[d]), 32'd0);
      checkOutput({tag, "_rvalid_early"}, 32'(rvalid[d]), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput({tag, "_rvalid_pre"}, 32'(rvalid[d]), 32'd0);
    @(posedge clk); #1;
    exp_dout = (w && !exp_err) ? data : last_dout[d];
    checkOutput({tag, "_rvalid"}, 32'(rvalid[d]), 32'd1);
    checkOutput({tag, "_ready_done"}, 32'(ready[d]), 32'd1);
    checkOutput({tag, "_err"}, 32'(err[d]), 32'(exp_err));
    checkOutput({tag, "_dout"}, dout[d], exp_dout);
    last_dout[d] = exp_dout;
    @(posedge clk); #1;
    checkOutput({tag, "_rvalid_drop"}, 32'(rvalid[d]), 32'd0);
    checkOutput({tag, "_err_drop"}, 32'(err[d]), 32'd0);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    req = 2'b00; wen = 2'b11;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; be[i] = '0; di[i] = '0; last_dout[i] = '0;
    end

    // Reset held with REQ toggling: block must stay idle and silent.
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req = {2{i[0]}};
      @(posedge clk); #1;
      checkOutput("rst_ready", 32'(ready[0]), 32'd1);
      checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_dout", dout[0], 32'd0);
    end
    req = 2'b00;
    rstn = 1'b1;
    @(posedge clk); #1;

    applyStimulus(0, 1'b0, 12'h010, 4'b1111, 32'hDEADBEEF, 3, 1'b0, "wr_010");
    applyStimulus(0, 1'b1, 12'h010, 4'b0000, 32'hDEADBEEF, 3, 1'b0, "rd_010");

    applyStimulus(0, 1'b0, 12'h005, 4'b1111, 32'h11223344, 3, 1'b0, "wr_005");
    applyStimulus(0, 1'b0, 12'h005, 4'b0101, 32'hAABBCCDD, 3, 1'b0, "wr_005_be");
    applyStimulus(0, 1'b1, 12'h005, 4'b0000, 32'h11BB33DD, 3, 1'b0, "rd_005_be");
    applyStimulus(0, 1'b0, 12'h005, 4'b0000, 32'hFFFFFFFF, 3, 1'b0, "wr_005_be0");
    applyStimulus(0, 1'b1, 12'h005, 4'b0000, 32'h11BB33DD, 3, 1'b0, "rd_005_be0");

    applyStimulus(0, 1'b0, 12'h000, 4'b1111, 32'hCAFEF00D, 3, 1'b0, "wr_000");
    applyStimulus(0, 1'b0, 12'h3FF, 4'b1111, 32'h5A5A0FF0, 3, 1'b0, "wr_3ff");
    applyStimulus(0, 1'b1, 12'h3FF, 4'b0000, 32'h5A5A0FF0, 3, 1'b0, "rd_3ff");
    applyStimulus(0, 1'b1, 12'h400, 4'b0000, 32'h00000000, 3, 1'b1, "rd_400_oor");
    applyStimulus(0, 1'b0, 12'h400, 4'b1111, 32'h12345678, 3, 1'b1, "wr_400_oor");
    applyStimulus(0, 1'b1, 12'h000, 4'b0000, 32'hCAFEF00D, 3, 1'b0, "rd_000_alias");
    applyStimulus(0, 1'b1, 12'h3FF, 4'b0000, 32'h5A5A0FF0, 3, 1'b0, "rd_3ff_after");

    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1'b0, 12'(i), 4'b1111, 32'hA5A50000 + 32'(i), 1, 1'b0, "l1_wr");

    // REQ held high at LATENCY=1: expect one completion every two cycles.
    req[1] = 1'b1; wen[1] = 1'b1; addr[1] = 12'h000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      addr[1] = 12'(i + 1);
      checkOutput("b2b_ready_low", 32'(ready[1]), 32'd0);
      checkOutput("b2b_rvalid_low", 32'(rvalid[1]), 32'd0);
      @(posedge clk); #1;
      if (i == 3) req[1] = 1'b0;
      checkOutput("b2b_rvalid", 32'(rvalid[1]), 32'd1);
      checkOutput("b2b_ready_high", 32'(ready[1]), 32'd1);
      checkOutput("b2b_dout", dout[1], 32'hA5A50000 + 32'(i));
    end
    @(posedge clk); #1;
    checkOutput("b2b_idle", 32'(rvalid[1]), 32'd0);

    applyStimulus(0, 1'b0, 12'h020, 4'b1111, 32'h0BADCAFE, 3, 1'b0, "wr_020");
    // Abort an in-flight write with reset before its completion edge.
    req[0] = 1'b1; wen[0] = 1'b0; addr[0] = 12'h020; be[0] = 4'b1111; di[0] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req[0] = 1'b0;
    checkOutput("abort_busy", 32'(ready[0]), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_rvalid_rst", 32'(rvalid[0]), 32'd0);
    end
    rstn = 1'b1;
    last_dout[0] = '0;
    last_dout[1] = '0;
    checkOutput("abort_ready_release", 32'(ready[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_rvalid", 32'(rvalid[0]), 32'd0);
    end
    applyStimulus(0, 1'b1, 12'h020, 4'b0000, 32'h0BADCAFE, 3, 1'b0, "rd_020_abort");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
